// File: rtl/car_trip_computer_if.sv
// Signal bundle between the gear/speed controller side and the trip computer.
// There is no valid/ready handshake on this bus: speed, gear and trip_clear
// are sampled on every rising clock edge, and every trip computer output is a
// register that reflects the inputs sampled at the previous edge.
interface car_trip_computer_if #(
   parameter int DIST_W  = 16,
   parameter int SHIFT_W = 8
);
   logic [6:0]         speed;
   logic [1:0]         gear;
   logic               trip_clear;
   logic [DIST_W-1:0]  odometer;
   logic [DIST_W-1:0]  trip_dist;
   logic [6:0]         max_speed;
   logic [SHIFT_W-1:0] shift_count;
   logic               overspeed;
   logic               gear_fault;

   // Producer of speed/gear/trip_clear, consumer of the trip results.
   modport master (
      output speed, gear, trip_clear,
      input  odometer, trip_dist, max_speed, shift_count, overspeed, gear_fault
   );

   // The trip computer itself.
   modport slave (
      input  speed, gear, trip_clear,
      output odometer, trip_dist, max_speed, shift_count, overspeed, gear_fault
   );
endinterface

// File: rtl/car_trip_computer.sv
// Car trip computer: integrates speed into odometer and trip distance,
// records peak trip speed, counts gear shifts, flags illegal gear codes and
// raises a debounced overspeed alarm with release hysteresis.
// UNIT_DIV must be >= 128 so that at most one distance unit accrues per cycle,
// OVER_OFF must be below OVER_ON, and HOLD must be at least 1.
module car_trip_computer #(
   parameter int UNIT_DIV = 200,
   parameter int DIST_W   = 16,
   parameter int OVER_ON  = 70,
   parameter int OVER_OFF = 65,
   parameter int HOLD     = 4,
   parameter int SHIFT_W  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   car_trip_computer_if.slave   bus,
   output logic [1:0]           o_alarm_state
);

   localparam int ACC_W  = $clog2(UNIT_DIV + 128);
   localparam int HOLD_W = $clog2(HOLD + 1);

   localparam logic [ACC_W:0]    L_UNIT     = (ACC_W+1)'(UNIT_DIV);
   localparam logic [HOLD_W-1:0] L_HOLD     = HOLD_W'(HOLD);
   localparam logic [6:0]        L_OVER_ON  = 7'(OVER_ON);
   localparam logic [6:0]        L_OVER_OFF = 7'(OVER_OFF);

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALARM   = 2'd2
   } alarm_state_t;

   // Registers
   logic [ACC_W-1:0]   r_acc;
   logic [DIST_W-1:0]  r_odometer;
   logic [DIST_W-1:0]  r_trip_dist;
   logic [6:0]         r_max_speed;
   logic [SHIFT_W-1:0] r_shift_count;
   logic [1:0]         r_prev_gear;
   logic               r_gear_fault;
   alarm_state_t       r_state;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic               r_overspeed;

   // Combinational helpers
   logic [ACC_W:0]     w_sum;
   logic [ACC_W:0]     w_sum_wrapped;
   logic               w_tick;
   logic [ACC_W-1:0]   w_acc_next;
   logic               w_over_on;
   logic               w_under_off;

   // Speed accumulation: one unit tick whenever the running sum crosses UNIT_DIV.
   always_comb begin
      w_sum         = {1'b0, r_acc} + {{(ACC_W-6){1'b0}}, bus.speed};
      w_sum_wrapped = w_sum - L_UNIT;
      w_tick        = (w_sum >= L_UNIT);
      w_acc_next    = w_tick ? w_sum_wrapped[ACC_W-1:0] : w_sum[ACC_W-1:0];
      w_over_on     = (bus.speed >= L_OVER_ON);
      w_under_off   = (bus.speed < L_OVER_OFF);
   end

   // Distance: odometer wraps, trip distance saturates; trip_clear wins over a tick for trip only.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc       <= '0;
         r_odometer  <= '0;
         r_trip_dist <= '0;
      end else begin
         r_acc <= bus.trip_clear ? '0 : w_acc_next;
         if (w_tick) begin
            r_odometer <= r_odometer + 1'b1;
         end
         if (bus.trip_clear) begin
            r_trip_dist <= '0;
         end else if (w_tick && (r_trip_dist != '1)) begin
            r_trip_dist <= r_trip_dist + 1'b1;
         end
      end
   end

   // Peak speed since the last trip clear; a clear restarts the peak at the current speed.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_max_speed <= '0;
      end else if (bus.trip_clear) begin
         r_max_speed <= bus.speed;
      end else if (bus.speed > r_max_speed) begin
         r_max_speed <= bus.speed;
      end
   end

   // Gear tracking: gear 0 is a sticky fault and is ignored for shift counting.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prev_gear   <= 2'd1;
         r_shift_count <= '0;
         r_gear_fault  <= 1'b0;
      end else if (bus.gear == 2'd0) begin
         r_gear_fault <= 1'b1;
      end else if (bus.gear != r_prev_gear) begin
         r_prev_gear <= bus.gear;
         if (r_shift_count != '1) begin
            r_shift_count <= r_shift_count + 1'b1;
         end
      end
   end

   // Overspeed alarm FSM; overspeed is registered together with each state transition.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_NORMAL;
         r_hold_cnt  <= '0;
         r_overspeed <= 1'b0;
      end else begin
         case (r_state)
            ST_NORMAL: begin
               if (w_over_on) begin
                  if (HOLD == 1) begin
                     r_state     <= ST_ALARM;
                     r_hold_cnt  <= '0;
                     r_overspeed <= 1'b1;
                  end else begin
                     r_state    <= ST_PENDING;
                     r_hold_cnt <= HOLD_W'(1);
                  end
               end
            end
            ST_PENDING: begin
               if (w_over_on) begin
                  if ((r_hold_cnt + 1'b1) == L_HOLD) begin
                     r_state     <= ST_ALARM;
                     r_hold_cnt  <= '0;
                     r_overspeed <= 1'b1;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + 1'b1;
                  end
               end else begin
                  r_state    <= ST_NORMAL;
                  r_hold_cnt <= '0;
               end
            end
            ST_ALARM: begin
               // Speeds in [OVER_OFF, OVER_ON) keep the alarm up (hysteresis band).
               if (w_under_off) begin
                  r_state     <= ST_NORMAL;
                  r_overspeed <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_NORMAL;
               r_hold_cnt  <= '0;
               r_overspeed <= 1'b0;
            end
         endcase
      end
   end

   assign bus.odometer    = r_odometer;
   assign bus.trip_dist   = r_trip_dist;
   assign bus.max_speed   = r_max_speed;
   assign bus.shift_count = r_shift_count;
   assign bus.overspeed   = r_overspeed;
   assign bus.gear_fault  = r_gear_fault;
   assign o_alarm_state   = r_state;

endmodule
